cofre_param: RTL
================

COFRE_PARAM -- requirements
Module: cofre_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DIGIT_W, 2, keypad digit width; code 0 means "no key".
- CODE_LEN, 5, number of digits in the combination.
- DEFAULT_CODE, 10'b11_10_01_10_11, reset combination; digit i at bits [i*DIGIT_W +: DIGIT_W], with digit 0 entered first.
- MAX_TRIES, 3, consecutive failures that trigger lockout.
- LOCKOUT_CYCLES, 16, lockout duration in clock cycles.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- digito, in, DIGIT_W, keypad digit; sampled every cycle.
- fecha, in, 1, relock request; acted on only in OPEN.
- prog, in, 1, start code programming; acted on only in OPEN, and only with COFRE_PROG_EN.
- led, out, 1, high only in OPEN.
- bloqueado, out, 1, high only in LOCKOUT.
- tentativas, out, $clog2(MAX_TRIES+1), current consecutive-failure count.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, ENTRY, OPEN, LOCKOUT and PROG.
REQ-004 In IDLE and ENTRY, digito==0 SHALL hold the state and the digit index idx.
REQ-005 In IDLE, a nonzero digito equal to code[0] SHALL move to ENTRY with idx=1; if CODE_LEN==1, it SHALL move to OPEN instead.
REQ-006 In ENTRY, a nonzero digito equal to code[idx] SHALL increment idx; when idx==CODE_LEN-1, it SHALL move to OPEN.
REQ-007 A nonzero wrong digit in IDLE or ENTRY SHALL be a failure: the FSM returns to IDLE, idx is cleared, and tentativas increments.
REQ-008 A failure that makes tentativas equal MAX_TRIES SHALL move to LOCKOUT, load the lockout timer with LOCKOUT_CYCLES-1, and clear tentativas.
REQ-009 In LOCKOUT, all inputs SHALL be ignored; the timer decrements each cycle and the FSM enters IDLE on the cycle after the timer reaches 0 (exactly LOCKOUT_CYCLES cycles in LOCKOUT).
REQ-010 Entry into OPEN SHALL clear tentativas.
REQ-011 OPEN SHALL persist until fecha=1, which moves the FSM to IDLE on the next edge.
REQ-012 If fecha and prog are both high in OPEN, fecha SHALL win.
REQ-013 led and bloqueado SHALL be Moore outputs decoded from the registered state only; neither depends combinationally on any input.
REQ-014 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-015 reset=0 SHALL asynchronously force state=IDLE, idx=0, tentativas=0, timer=0, code register=DEFAULT_CODE, led=0 and bloqueado=0.
REQ-016 Reset asserted mid-entry, mid-lockout or mid-programming SHALL abort that operation with no partial effects retained.
REQ-017 Release of reset SHALL take effect on the first rising clk edge after deassertion.

Configuration
REQ-018 With COFRE_PROG_EN defined:
- prog=1 with fecha=0 in OPEN SHALL enter PROG with idx=0.
- In PROG, each nonzero digito SHALL be written to code[idx] and idx incremented; zeros are skipped.
- After CODE_LEN digits, the FSM SHALL return to OPEN and the new code takes effect on the next edge.
- A zero digit can never become part of the code.
REQ-019 Without COFRE_PROG_EN:
- the PROG state SHALL not be synthesised and the prog port is ignored;
- the code SHALL be the constant DEFAULT_CODE.

Structure
REQ-020 The package cofre_pkg SHALL hold the state enum typedef and the digit constant for "no key" (0).
REQ-021 The lockout down-counter SHALL be a sub-module, cofre_timer, with load, count-enable and zero-flag ports.
REQ-022 The code register and FSM SHALL remain in cofre_param.

Verification
REQ-023 Default code: digito 3,0,2,1,0,2,3 on consecutive cycles -> led=1 on the cycle after the final 3; tentativas=0.
REQ-024 Entry 3,2,2 -> state IDLE after the second 2 with tentativas=1; then 3,2,1,2,3 -> led=1 and tentativas=0.
REQ-025 Three consecutive wrong digits 1,1,1 -> bloqueado=1 for exactly 16 cycles with led=0 even if the correct code is applied meanwhile; then IDLE with tentativas=0.
REQ-026 In OPEN, fecha=1 and prog=1 together -> IDLE and led=0; the code is unchanged.
REQ-027 With COFRE_PROG_EN: in OPEN, prog=1, then 1,0,1,1,1,1 -> OPEN; fecha; then 1,1,1,1,1 -> led=1; the old code 3,2,1,2,3 fails with tentativas=1.
REQ-028 reset=0 pulse between clock edges during LOCKOUT -> outputs clear immediately, with no clock edge required; the code reverts to DEFAULT_CODE.

Source files
------------

// File: rtl/cofre_pkg.sv
// rtl/cofre_pkg.sv - shared state encoding and keypad constants for the cofre lock
package cofre_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        OPEN    = 3'd2,
        LOCKOUT = 3'd3,
        PROG    = 3'd4
    } state_t;

    localparam int NO_KEY = 0;

endpackage

// File: rtl/cofre_timer.sv
// rtl/cofre_timer.sv - loadable lockout down-counter with zero flag
module cofre_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cofre_param.sv
// rtl/cofre_param.sv - combination lock FSM with lockout; COFRE_PROG_EN enables code programming
module cofre_param
    import cofre_pkg::*;
#(
    parameter int                         DIGIT_W        = 2,
    parameter int                         CODE_LEN       = 5,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE  = 10'b11_10_01_10_11,
    parameter int                         MAX_TRIES      = 3,
    parameter int                         LOCKOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DIGIT_W-1:0]             digito,
    input  logic                           fecha,
    input  logic                           prog,
    output logic                           led,
    output logic                           bloqueado,
    output logic [$clog2(MAX_TRIES+1)-1:0] tentativas
);

    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TW    = $clog2(MAX_TRIES + 1);
    localparam int CW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    state_t                        state, next_state;
    logic [IDX_W-1:0]              idx, next_idx, pos;
    logic [TW-1:0]                 tries, next_tries;
    logic [DIGIT_W*CODE_LEN-1:0]   code;
    logic                          timer_load, timer_en, timer_zero;
    logic                          key_hit;
    logic [DIGIT_W-1:0]            expected_digit;

    assign key_hit = (digito != DIGIT_W'(NO_KEY));

    cofre_timer #(.WIDTH(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (CW'(LOCKOUT_CYCLES - 1)),
        .en         (timer_en),
        .zero       (timer_zero)
    );

`ifdef COFRE_PROG_EN
    logic code_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code <= DEFAULT_CODE;
        end else if (code_we) begin
            code[idx*DIGIT_W +: DIGIT_W] <= digito;
        end
    end
`else
    logic unused_prog;

    assign code        = DEFAULT_CODE;
    assign unused_prog = prog;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            tries <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            tries <= next_tries;
        end
    end

    // IDLE always compares against digit 0, so a stale idx can never skip digits
    always_comb begin
        next_state     = state;
        next_idx       = idx;
        next_tries     = tries;
        timer_load     = 1'b0;
        timer_en       = 1'b0;
        pos            = (state == IDLE) ? '0 : idx;
        expected_digit = code[pos*DIGIT_W +: DIGIT_W];
`ifdef COFRE_PROG_EN
        code_we        = 1'b0;
`endif
        case (state)
            IDLE, ENTRY: begin
                if (key_hit) begin
                    if (digito == expected_digit) begin
                        if (pos == IDX_W'(CODE_LEN - 1)) begin
                            next_state = OPEN;
                            next_idx   = '0;
                            next_tries = '0;
                        end else begin
                            next_state = ENTRY;
                            next_idx   = pos + IDX_W'(1);
                        end
                    end else begin
                        next_idx = '0;
                        if (tries == TW'(MAX_TRIES - 1)) begin
                            next_state = LOCKOUT;
                            next_tries = '0;
                            timer_load = 1'b1;
                        end else begin
                            next_state = IDLE;
                            next_tries = tries + TW'(1);
                        end
                    end
                end
            end
            OPEN: begin
                if (fecha) begin
                    next_state = IDLE;
                    next_idx   = '0;
`ifdef COFRE_PROG_EN
                end else if (prog) begin
                    next_state = PROG;
                    next_idx   = '0;
`endif
                end
            end
            LOCKOUT: begin
                if (timer_zero) begin
                    next_state = IDLE;
                    next_idx   = '0;
                end else begin
                    timer_en = 1'b1;
                end
            end
`ifdef COFRE_PROG_EN
            PROG: begin
                if (key_hit) begin
                    code_we = 1'b1;
                    if (idx == IDX_W'(CODE_LEN - 1)) begin
                        next_state = OPEN;
                        next_idx   = '0;
                    end else begin
                        next_idx = idx + IDX_W'(1);
                    end
                end
            end
`endif
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase
    end

    always_comb begin
        led       = (state == OPEN);
        bloqueado = (state == LOCKOUT);
    end

    assign tentativas = tries;

endmodule
